// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampling UART receiver with sticky error flags and a fall-through receive FIFO
module uart_rx_fifo #(
  parameter int DIV        = 326,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        rxd,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] BRK   = 3'd5;

  logic                 rxd_s1, rxd_s2, rxd_d;
  logic [2:0]           state;
  logic [DW-1:0]        div_cnt;
  logic [3:0]           tick_cnt;
  logic [1:0]           samp;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;

  logic start_edge, tick, mid, bit_end, maj, par_exp;
  logic stop_mid, push, pop, full, do_write;
  logic set_fe, set_pe, set_ov;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_d  <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_d  <= rxd_s2;
    end
  end

  assign start_edge = rxd_d & ~rxd_s2;
  assign tick       = (div_cnt == DIV_LAST);
  assign mid        = tick && (tick_cnt == 4'd9);
  assign bit_end    = tick && (tick_cnt == 4'd15);
  // samples from ticks 7 and 8 are registered; tick 9 uses the live synced value
  assign maj        = (samp[0] & samp[1]) | (samp[0] & rxd_s2) | (samp[1] & rxd_s2);
  assign par_exp    = (PARITY == 2) ? ^shreg : ~^shreg;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      tick_cnt <= 4'd0;
      samp     <= 2'b00;
      bit_cnt  <= 3'd0;
      shreg    <= '0;
      par_bad  <= 1'b0;
    end else if (state == IDLE) begin
      div_cnt  <= '0;
      tick_cnt <= 4'd0;
      if (start_edge) state <= START;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
        if (tick_cnt == 4'd7) samp[0] <= rxd_s2;
        if (tick_cnt == 4'd8) samp[1] <= rxd_s2;
      end
      case (state)
        START: begin
          if (mid && maj) begin
            state <= IDLE;
          end else if (bit_end) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
            par_bad <= 1'b0;
          end
        end
        DATA: begin
          if (mid) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) state <= (PARITY != 0) ? PAR : STOP;
            else bit_cnt <= bit_cnt + 3'd1;
          end
        end
        PAR: begin
          if (mid) par_bad <= maj ^ par_exp;
          if (bit_end) state <= STOP;
        end
        // leaving at the stop midpoint gives slack for back-to-back frames
        STOP: if (mid) state <= maj ? IDLE : BRK;
        BRK:  if (rxd_s2) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;

  assign stop_mid = (state == STOP) && mid;
  assign push     = stop_mid && maj && !par_bad;
  assign set_fe   = stop_mid && !maj;
  assign set_pe   = stop_mid && maj && par_bad;
  assign pop      = rd_en && rx_valid;
  assign full     = (rx_count == FULL_CNT);
  assign set_ov   = push && full && !pop;
  assign do_write = push && (!full || pop);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign rx_count = wr_ptr - rd_ptr;
  assign rx_valid = (rx_count != '0);
  assign rx_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= set_fe | (frame_err  & ~clr_err);
      parity_err <= set_pe | (parity_err & ~clr_err);
      overrun    <= set_ov | (overrun    & ~clr_err);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo: 8N1, even/odd parity and 5-bit receivers at DIV=4
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int BIT = 64;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [3:0] rxd, rd_en, clr_err;
  logic [7:0] d0, d1, d2;
  logic [4:0] d3;
  logic [2:0] cnt0, cnt1, cnt2, cnt3;
  logic [3:0] valid, fe, pe, ov;

  int errors = 0;
  int checks = 0;

  always #5 sysclk = ~sysclk;

  uart_rx_fifo #(.DIV(4), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_8n1 (
    .sysclk(sysclk), .reset(reset), .rxd(rxd[0]), .rd_en(rd_en[0]), .clr_err(clr_err[0]),
    .rx_data(d0), .rx_valid(valid[0]), .rx_count(cnt0),
    .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]));

  uart_rx_fifo #(.DIV(4), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) u_even (
    .sysclk(sysclk), .reset(reset), .rxd(rxd[1]), .rd_en(rd_en[1]), .clr_err(clr_err[1]),
    .rx_data(d1), .rx_valid(valid[1]), .rx_count(cnt1),
    .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]));

  uart_rx_fifo #(.DIV(4), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4)) u_odd (
    .sysclk(sysclk), .reset(reset), .rxd(rxd[2]), .rd_en(rd_en[2]), .clr_err(clr_err[2]),
    .rx_data(d2), .rx_valid(valid[2]), .rx_count(cnt2),
    .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]));

  uart_rx_fifo #(.DIV(4), .DATA_BITS(5), .PARITY(0), .FIFO_DEPTH(4)) u_db5 (
    .sysclk(sysclk), .reset(reset), .rxd(rxd[3]), .rd_en(rd_en[3]), .clr_err(clr_err[3]),
    .rx_data(d3), .rx_valid(valid[3]), .rx_count(cnt3),
    .frame_err(fe[3]), .parity_err(pe[3]), .overrun(ov[3]));

  task automatic bit_out(input int ch, input logic v, input int cyc);
    rxd[ch] = v;
    repeat (cyc) @(negedge sysclk);
  endtask

  // par < 0 means no parity bit; otherwise par[0] is the bit sent
  task automatic send_frame(input int ch, input logic [7:0] data, input int nbits,
                            input int par, input logic stop_b, input int cyc);
    bit_out(ch, 1'b0, cyc);
    for (int i = 0; i < nbits; i++) bit_out(ch, data[i], cyc);
    if (par >= 0) bit_out(ch, par[0], cyc);
    bit_out(ch, stop_b, cyc);
  endtask

  task automatic pop(input int ch);
    rd_en[ch] = 1'b1;
    @(negedge sysclk);
    rd_en[ch] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; rxd = 4'hF; rd_en = 4'h0; clr_err = 4'h0;
    repeat (5) @(negedge sysclk);
    checks++; if (valid !== 4'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0000", valid); end
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", cnt0); end
    checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", d0); end
    checks++; if ({fe, pe, ov} !== 12'h000) begin errors++; $display("FAIL rst_flags got=%h exp=000", {fe, pe, ov}); end
    reset = 1'b1;
    repeat (5) @(negedge sysclk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [3] = '{8'h96, 8'hB9, 8'h1E};
    for (int i = 0; i < 3; i++) begin
      send_frame(0, exp_b[i], 8, -1, 1'b1, BIT);
      bit_out(0, 1'b1, BIT);
    end
    checks++; if (cnt0 !== 3'd3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", cnt0); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (d0 !== exp_b[i]) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, d0, exp_b[i]); end
      pop(0);
    end
    checks++; if (valid[0] !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", valid[0]); end
    checks++; if ({fe[0], pe[0], ov[0]} !== 3'b000) begin errors++; $display("FAIL b2b_flags got=%b exp=000", {fe[0], pe[0], ov[0]}); end
  endtask

  task automatic test_glitch;
    bit_out(0, 1'b0, 4);
    bit_out(0, 1'b1, 3 * BIT);
    checks++; if (valid[0] !== 1'b0) begin errors++; $display("FAIL glitch_valid got=%b exp=0", valid[0]); end
    checks++; if ({fe[0], pe[0], ov[0]} !== 3'b000) begin errors++; $display("FAIL glitch_flags got=%b exp=000", {fe[0], pe[0], ov[0]}); end
    send_frame(0, 8'h3C, 8, -1, 1'b1, BIT);
    bit_out(0, 1'b1, BIT);
    checks++; if (cnt0 !== 3'd1 || d0 !== 8'h3C) begin errors++; $display("FAIL glitch_rearm got=%0d/%h exp=1/3c", cnt0, d0); end
    pop(0);
  endtask

  task automatic test_framing;
    send_frame(0, 8'h55, 8, -1, 1'b0, BIT);
    bit_out(0, 1'b0, 40 * BIT);
    checks++; if (fe[0] !== 1'b1) begin errors++; $display("FAIL frm_flag got=%b exp=1", fe[0]); end
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL frm_count got=%0d exp=0", cnt0); end
    bit_out(0, 1'b1, 2 * BIT);
    send_frame(0, 8'hA5, 8, -1, 1'b1, BIT);
    bit_out(0, 1'b1, BIT);
    checks++; if (cnt0 !== 3'd1 || d0 !== 8'hA5) begin errors++; $display("FAIL frm_after got=%0d/%h exp=1/a5", cnt0, d0); end
    checks++; if (fe[0] !== 1'b1) begin errors++; $display("FAIL frm_sticky got=%b exp=1", fe[0]); end
    pop(0);
    clr_err[0] = 1'b1;
    @(negedge sysclk);
    clr_err[0] = 1'b0;
    checks++; if (fe[0] !== 1'b0) begin errors++; $display("FAIL frm_clear got=%b exp=0", fe[0]); end
  endtask

  task automatic test_parity;
    // 0x07 has three ones: even parity bit is 1, odd parity bit is 0
    send_frame(1, 8'h07, 8, 1, 1'b1, BIT);  bit_out(1, 1'b1, BIT);
    checks++; if (cnt1 !== 3'd1 || d1 !== 8'h07 || pe[1] !== 1'b0) begin errors++; $display("FAIL par_even_ok got=%0d/%h/%b exp=1/07/0", cnt1, d1, pe[1]); end
    send_frame(1, 8'h07, 8, 0, 1'b1, BIT);  bit_out(1, 1'b1, BIT);
    checks++; if (cnt1 !== 3'd1 || pe[1] !== 1'b1 || fe[1] !== 1'b0) begin errors++; $display("FAIL par_even_bad got=%0d/%b/%b exp=1/1/0", cnt1, pe[1], fe[1]); end
    send_frame(2, 8'h07, 8, 0, 1'b1, BIT);  bit_out(2, 1'b1, BIT);
    checks++; if (cnt2 !== 3'd1 || d2 !== 8'h07 || pe[2] !== 1'b0) begin errors++; $display("FAIL par_odd_ok got=%0d/%h/%b exp=1/07/0", cnt2, d2, pe[2]); end
    send_frame(2, 8'h07, 8, 1, 1'b1, BIT);  bit_out(2, 1'b1, BIT);
    checks++; if (cnt2 !== 3'd1 || pe[2] !== 1'b1 || fe[2] !== 1'b0) begin errors++; $display("FAIL par_odd_bad got=%0d/%b/%b exp=1/1/0", cnt2, pe[2], fe[2]); end
  endtask

  task automatic test_overrun;
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 8'(i), 8, -1, 1'b1, BIT);
      bit_out(0, 1'b1, BIT);
    end
    checks++; if (ov[0] !== 1'b1 || cnt0 !== 3'd4) begin errors++; $display("FAIL ovr_full got=%b/%0d exp=1/4", ov[0], cnt0); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (d0 !== 8'(i)) begin errors++; $display("FAIL ovr_pop%0d got=%h exp=%h", i, d0, 8'(i)); end
      pop(0);
    end
    clr_err[0] = 1'b1; @(negedge sysclk); clr_err[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send_frame(0, 8'(i), 8, -1, 1'b1, BIT);
      bit_out(0, 1'b1, BIT);
    end
    // start bit at negedge 0; stop-bit tick 9 lands on posedge 619
    fork
      send_frame(0, 8'h05, 8, -1, 1'b1, BIT);
      begin
        repeat (618) @(negedge sysclk);
        checks++; if (cnt0 !== 3'd4) begin errors++; $display("FAIL ovr_pre got=%0d exp=4", cnt0); end
        rd_en[0] = 1'b1;
        @(negedge sysclk);
        rd_en[0] = 1'b0;
        checks++; if (ov[0] !== 1'b0 || cnt0 !== 3'd4) begin errors++; $display("FAIL ovr_simul got=%b/%0d exp=0/4", ov[0], cnt0); end
      end
    join
    bit_out(0, 1'b1, BIT);
    for (int i = 2; i <= 5; i++) begin
      checks++; if (d0 !== 8'(i)) begin errors++; $display("FAIL ovr_keep%0d got=%h exp=%h", i, d0, 8'(i)); end
      pop(0);
    end
    checks++; if (ov[0] !== 1'b0 || valid[0] !== 1'b0) begin errors++; $display("FAIL ovr_end got=%b/%b exp=0/0", ov[0], valid[0]); end
  endtask

  task automatic test_db5_tolerance;
    send_frame(3, 8'h1B, 5, -1, 1'b1, 67);  bit_out(3, 1'b1, 67);
    checks++; if (cnt3 !== 3'd1 || d3 !== 5'h1B) begin errors++; $display("FAIL db5_slow got=%0d/%h exp=1/1b", cnt3, d3); end
    send_frame(3, 8'h1B, 5, -1, 1'b1, 61);  bit_out(3, 1'b1, 61);
    checks++; if (cnt3 !== 3'd2) begin errors++; $display("FAIL db5_fast_cnt got=%0d exp=2", cnt3); end
    pop(3);
    checks++; if (d3 !== 5'h1B || fe[3] !== 1'b0) begin errors++; $display("FAIL db5_fast got=%h/%b exp=1b/0", d3, fe[3]); end
    fork
      send_frame(3, 8'h1B, 5, -1, 1'b1, BIT);
      begin
        repeat (2 * BIT + 30) @(negedge sysclk);
        reset = 1'b0;
        #1;
        checks++; if (cnt3 !== 3'd0 || valid[3] !== 1'b0) begin errors++; $display("FAIL db5_rst got=%0d/%b exp=0/0", cnt3, valid[3]); end
      end
    join
    bit_out(3, 1'b1, BIT);
    reset = 1'b1;
    bit_out(3, 1'b1, BIT);
    send_frame(3, 8'h0A, 5, -1, 1'b1, BIT);  bit_out(3, 1'b1, BIT);
    checks++; if (cnt3 !== 3'd1 || d3 !== 5'h0A) begin errors++; $display("FAIL db5_after got=%0d/%h exp=1/0a", cnt3, d3); end
    checks++; if ({fe[3], pe[3], ov[3]} !== 3'b000) begin errors++; $display("FAIL db5_flags got=%b exp=000", {fe[3], pe[3], ov[3]}); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_parity;
    test_overrun;
    test_db5_tolerance;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
